mask_modulator: RTL and testbench

Parametrised M-level amplitude-shift-keying modulator: the next generation of the board's binary ASK datapath. It packs a serial bit stream into BPS-bit symbols, maps each symbol to one of 2^BPS carrier amplitudes with a linear amplitude ramp, and multiplies a programmable-frequency DDS sine by that amplitude. The result is an unsigned offset-binary sample for the GPIO DAC. It sits between the PRBS/manual bit source and the DAC pins, replacing the fixed keying controller, DDS and modulator chain.

---
 rtl/mask_pkg.sv | 53 +++++
 rtl/mask_sine_lut.sv | 31 +++
 rtl/mask_modulator.sv | 144 ++++++++++++++
 tb/tb_mask_modulator.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mask_pkg.sv
// Shared helpers for the M-level ASK modulator: level scaling, midscale offset
// and the integer sine generator used to fill the carrier ROM at elaboration.
package mask_pkg;

  localparam int     SINE_Q     = 30;
  localparam longint Q_ONE      = 64'sd1 << SINE_Q;
  localparam longint TWO_PI_Q   = 64'sd6746518852;
  localparam int     SINE_TERMS = 10;

  function automatic int mask_level_scale(input int dataW, input int bps);
    return ((1 << (dataW - 1)) - 1) / ((1 << bps) - 1);
  endfunction

  function automatic int mask_midscale(input int dataW);
    return 1 << (dataW - 1);
  endfunction

  // Taylor series in Q30 fixed point; only called for angles in [0, pi/2].
  function automatic longint mask_sin_q(input longint theta);
    longint x2;
    longint term;
    longint sum;
    x2   = (theta * theta) >>> SINE_Q;
    term = theta;
    sum  = theta;
    for (int k = 1; k <= SINE_TERMS; k++) begin
      term = -(((term * x2) >>> SINE_Q) / longint'((2 * k) * (2 * k + 1)));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic int mask_sine_entry(input int dataW, input int lutAw, input int idx);
    int     n;
    int     quarter;
    int     q;
    int     r;
    int     j;
    longint s;
    longint amp;
    longint v;
    n       = 1 << lutAw;
    quarter = n / 4;
    q       = idx / quarter;
    r       = idx % quarter;
    j       = ((q % 2) == 0) ? r : (quarter - r);
    s       = mask_sin_q((TWO_PI_Q * longint'(j)) / longint'(n));
    amp     = longint'((1 << (dataW - 1)) - 1);
    v       = (amp * s + (Q_ONE >>> 1)) >>> SINE_Q;
    return (q >= 2) ? -int'(v) : int'(v);
  endfunction

endpackage

// File: rtl/mask_sine_lut.sv
// Full-wave signed sine ROM with a single registered read port.
module mask_sine_lut
  import mask_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int LUT_AW = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LUT_AW-1:0]        i_addr,
  output logic signed [DATA_W-1:0] o_data
);

  localparam int DEPTH = 1 << LUT_AW;

  logic signed [DATA_W-1:0] w_rom [DEPTH];
  logic signed [DATA_W-1:0] r_data;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    localparam int ENTRY = mask_sine_entry(DATA_W, LUT_AW, gi);
    assign w_rom[gi] = DATA_W'(ENTRY);
  end

  always_ff @(posedge clk) begin
    if (reset) r_data <= '0;
    else       r_data <= w_rom[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/mask_modulator.sv
// M-level ASK modulator: serial bits -> BPS-bit symbols -> ramped amplitude
// that scales a DDS sine, producing an offset-binary DAC sample.
module mask_modulator
  import mask_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int BPS       = 2,
  parameter int PHASE_W   = 24,
  parameter int LUT_AW    = 8,
  parameter int SYM_DIV   = 50000,
  parameter int RAMP_STEP = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  output logic               sym_strobe,
  output logic               underrun,
  output logic [BPS-1:0]     level_out,
  output logic [DATA_W-1:0]  ask_out
);

  localparam int AMP_W   = DATA_W - 1;
  localparam int PROD_W  = 2 * DATA_W - 1;
  localparam int TIMER_W = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;
  localparam int CNT_W   = $clog2(BPS + 1);
  localparam int K       = mask_level_scale(DATA_W, BPS);
  localparam int MID     = mask_midscale(DATA_W);

  logic [TIMER_W-1:0] r_timer;
  logic [PHASE_W-1:0] r_phase;
  logic [CNT_W-1:0]   r_count;
  logic [BPS-1:0]     r_shift;
  logic [BPS-1:0]     r_level;
  logic [AMP_W-1:0]   r_target;
  logic [AMP_W-1:0]   r_amp;
  logic [AMP_W-1:0]   r_ampD;
  logic               r_underrun;
  logic [DATA_W-1:0]  r_ask;

  logic                     w_full;
  logic                     w_take;
  logic                     w_strobe;
  logic [31:0]              w_gap;
  logic [AMP_W-1:0]         w_ampNext;
  logic signed [DATA_W-1:0] w_sine;
  logic signed [PROD_W-1:0] w_sineX;
  logic signed [PROD_W-1:0] w_ampX;
  logic signed [PROD_W-1:0] w_prod;
  logic [DATA_W-1:0]        w_mod;

  assign w_full    = (r_count == CNT_W'(BPS));
  assign bit_ready = enable && !reset && (r_count < CNT_W'(BPS));
  assign w_take    = bit_valid && bit_ready;
  assign w_strobe  = enable && !reset && (r_timer == TIMER_W'(SYM_DIV - 1));

  // Timer, assembler and symbol loading; a full assembler blocks transfers,
  // so a load and a shift never collide on r_count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer    <= '0;
      r_phase    <= '0;
      r_count    <= '0;
      r_shift    <= '0;
      r_level    <= '0;
      r_target   <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (enable) begin
        r_timer <= w_strobe ? '0 : r_timer + TIMER_W'(1);
        r_phase <= r_phase + phase_inc;
      end
      if (w_take) begin
        r_shift <= BPS'({r_shift, bit_in});
        r_count <= r_count + CNT_W'(1);
      end
      if (!enable) begin
        r_target <= '0;
      end else if (w_strobe) begin
        if (w_full) begin
          r_level  <= r_shift;
          r_target <= AMP_W'(K) * AMP_W'(r_shift);
          r_count  <= '0;
        end else begin
          r_level    <= '0;
          r_target   <= '0;
          r_underrun <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_ampNext = r_amp;
    w_gap     = '0;
    if (r_target > r_amp) begin
      w_gap = 32'(r_target) - 32'(r_amp);
      if (w_gap > 32'(RAMP_STEP)) w_ampNext = r_amp + AMP_W'(RAMP_STEP);
      else                        w_ampNext = r_target;
    end else if (r_amp > r_target) begin
      w_gap = 32'(r_amp) - 32'(r_target);
      if (w_gap > 32'(RAMP_STEP)) w_ampNext = r_amp - AMP_W'(RAMP_STEP);
      else                        w_ampNext = r_target;
    end
  end

  mask_sine_lut #(
    .DATA_W (DATA_W),
    .LUT_AW (LUT_AW)
  ) u_lut (
    .clk    (clk),
    .reset  (reset),
    .i_addr (r_phase[PHASE_W-1 -: LUT_AW]),
    .o_data (w_sine)
  );

  assign w_sineX = {{(PROD_W - DATA_W){w_sine[DATA_W-1]}}, w_sine};
  assign w_ampX  = {{(PROD_W - AMP_W){1'b0}}, r_ampD};
  assign w_prod  = w_sineX * w_ampX;
  assign w_mod   = DATA_W'(w_prod >>> (DATA_W - 1));

  // Amplitude is delayed one stage so it meets the sine from the registered ROM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_amp  <= '0;
      r_ampD <= '0;
      r_ask  <= DATA_W'(MID);
    end else begin
      r_amp  <= w_ampNext;
      r_ampD <= r_amp;
      r_ask  <= DATA_W'(MID) + w_mod;
    end
  end

  assign sym_strobe = w_strobe;
  assign underrun   = r_underrun;
  assign level_out  = r_level;
  assign ask_out    = r_ask;

endmodule

// File: tb/tb_mask_modulator.sv
// Scoreboard bench: a behavioural model predicts every cycle's outputs, a
// separate monitor pops and compares them on the falling edge.
module tb_mask_modulator;

  localparam int DW    = 12;
  localparam int BPS   = 2;
  localparam int PW    = 24;
  localparam int AW    = 8;
  localparam int SD    = 40;
  localparam int STEP  = 100;
  localparam int MID   = 1 << (DW - 1);
  localparam int AMAX  = MID - 1;
  localparam int SCALE = AMAX / ((1 << BPS) - 1);

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          enable    = 1'b0;
  logic [PW-1:0] phase_inc = '0;
  logic          bit_in    = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_ready;
  logic          sym_strobe;
  logic          underrun;
  logic [BPS-1:0] level_out;
  logic [DW-1:0]  ask_out;

  typedef struct {
    int ready;
    int strobe;
    int under;
    int level;
    int ask;
  } obs_t;

  obs_t   expQ[$];
  int     testsRun    = 0;
  int     testsFailed = 0;
  int     cycleNo     = 0;
  int     sineTab[1 << AW];

  int     mTimer, mLevel, mTarget, mAmp, mAmpPipe, mSinePipe, mAsk, mUnder;
  longint mPhase;
  int     mBits[$];

  mask_modulator #(
    .DATA_W    (DW),
    .BPS       (BPS),
    .PHASE_W   (PW),
    .LUT_AW    (AW),
    .SYM_DIV   (SD),
    .RAMP_STEP (STEP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .phase_inc  (phase_inc),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .sym_strobe (sym_strobe),
    .underrun   (underrun),
    .level_out  (level_out),
    .ask_out    (ask_out)
  );

  always #5 clk = ~clk;

  function automatic longint floorDiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic modelReset();
    mTimer = 0; mLevel = 0; mTarget = 0; mAmp = 0; mAmpPipe = 0;
    mSinePipe = 0; mAsk = MID; mUnder = 0; mPhase = 0;
    mBits.delete();
  endtask

  // Predict this cycle's outputs, queue them, then advance the model across the next edge.
  task automatic applyStimulus(input logic rst, input logic en, input int inc,
                               input logic b, input logic v);
    obs_t   e;
    longint prod;
    int     nAsk, nSine, nAmp, sym;
    logic   ready, strobe;
    reset = rst; enable = en; phase_inc = PW'(inc); bit_in = b; bit_valid = v;
    ready  = en && !rst && (mBits.size() < BPS);
    strobe = en && !rst && (mTimer == SD - 1);
    e.ready = int'(ready); e.strobe = int'(strobe);
    e.under = mUnder; e.level = mLevel; e.ask = mAsk;
    expQ.push_back(e);
    if (rst) begin
      modelReset();
    end else begin
      prod  = longint'(mSinePipe) * longint'(mAmpPipe);
      nAsk  = MID + int'(floorDiv(prod, longint'(MID)));
      nSine = sineTab[int'(mPhase / (longint'(1) << (PW - AW)))];
      if (mAmp < mTarget)      nAmp = (mTarget - mAmp > STEP) ? mAmp + STEP : mTarget;
      else if (mAmp > mTarget) nAmp = (mAmp - mTarget > STEP) ? mAmp - STEP : mTarget;
      else                     nAmp = mAmp;
      mAmpPipe = mAmp; mAmp = nAmp; mSinePipe = nSine; mAsk = nAsk;
      mUnder = 0;
      if (!en) begin
        mTarget = 0;
      end else if (strobe) begin
        if (mBits.size() == BPS) begin
          sym = 0;
          foreach (mBits[i]) sym = sym * 2 + mBits[i];
          mLevel = sym; mTarget = sym * SCALE;
          mBits.delete();
        end else begin
          mLevel = 0; mTarget = 0; mUnder = 1;
        end
      end
      if (ready && v) mBits.push_back(int'(b));
      if (en) begin
        mTimer = (mTimer + 1) % SD;
        mPhase = (mPhase + longint'(inc)) % (longint'(1) << PW);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input obs_t e);
    testsRun++;
    if ($isunknown({bit_ready, sym_strobe, underrun, level_out, ask_out}) ||
        int'(bit_ready) != e.ready || int'(sym_strobe) != e.strobe ||
        int'(underrun) != e.under || int'(level_out) != e.level || int'(ask_out) != e.ask) begin
      testsFailed++;
      $display("[TB] FAIL outputs cycle %0d: got rdy=%0d stb=%0d und=%0d lvl=%0d ask=%0d, want rdy=%0d stb=%0d und=%0d lvl=%0d ask=%0d",
               cycleNo, bit_ready, sym_strobe, underrun, level_out, ask_out,
               e.ready, e.strobe, e.under, e.level, e.ask);
    end
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
        cycleNo++;
      end
    end
  end

  initial begin : stimulus
    real r;
    int  inc;
    for (int i = 0; i < (1 << AW); i++) begin
      r = real'(AMAX) * $sin(2.0 * 3.141592653589793 * real'(i) / real'(1 << AW));
      sineTab[i] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    end
    modelReset();
    repeat (3) @(posedge clk);
    #1;

    // Idle after reset: first boundary must report an underrun.
    for (int i = 0; i < SD + 6; i++) applyStimulus(1'b0, 1'b1, 65536, 1'b0, 1'b0);

    // Full-scale symbols at a slow carrier to reach the waveform extremes.
    for (int i = 0; i < 6 * SD; i++) applyStimulus(1'b0, 1'b1, 65536, 1'b1, 1'b1);

    // Random bits, random validity, random tuning word.
    for (int i = 0; i < 8 * SD; i++) begin
      inc = (i % SD == 0) ? $urandom_range(1, 1 << 20) : inc;
      applyStimulus(1'b0, 1'b1, inc, 1'($urandom), 1'(($urandom % 4) != 0));
    end

    // A single bit, then starvation across several boundaries, then completion.
    applyStimulus(1'b0, 1'b1, 65536, 1'b1, 1'b1);
    for (int i = 0; i < 3 * SD; i++) applyStimulus(1'b0, 1'b1, 65536, 1'b0, 1'b0);
    for (int i = 0; i < 2 * SD; i++) applyStimulus(1'b0, 1'b1, 65536, 1'b0, 1'b1);

    // Enable dropped mid-symbol while bits keep arriving.
    for (int i = 0; i < SD / 2; i++) applyStimulus(1'b0, 1'b1, 40000, 1'($urandom), 1'b1);
    for (int i = 0; i < 10; i++)     applyStimulus(1'b0, 1'b0, 40000, 1'($urandom), 1'b1);
    for (int i = 0; i < 3 * SD; i++) applyStimulus(1'b0, 1'b1, 40000, 1'($urandom), 1'b1);

    // Reset in the middle of a symbol with one bit assembled.
    for (int i = 0; i < SD / 3; i++) applyStimulus(1'b0, 1'b1, 70000, 1'b1, 1'(i == 3));
    for (int i = 0; i < 2; i++)      applyStimulus(1'b1, 1'b1, 70000, 1'b1, 1'b1);
    for (int i = 0; i < 4 * SD; i++) applyStimulus(1'b0, 1'b1, 70000, 1'($urandom), 1'(($urandom % 3) != 0));

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
